seconds_counter: RTL and testbench
==================================

Name: seconds_counter

Overview:
Upstream timekeeping stage for the seconds display controller. It divides the system clock down to a 1 Hz tick and keeps two BCD digits: right (0-9) and left (0-5). Those digits feed the display controller's right/left seconds inputs. It also produces a one-cycle carry pulse on 59->00 for the minutes stage, and supports run/stop, clear and a validated load of a preset time.

Parameters:
TICKS_PER_SEC, 50000000, clk cycles per second; must be >= 2; benches override to 4.
PRESC_W, 26, prescaler width; must satisfy 2^PRESC_W >= TICKS_PER_SEC.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous reset, active-high.
run  input  1  level; 1 = prescaler counts, 0 = time frozen.
clear  input  1  one-cycle strobe; zero digits and prescaler.
load  input  1  one-cycle strobe; load preset digits.
load_right  input  4  preset right digit, valid 0-9.
load_left  input  3  preset left digit, valid 0-5.
rightSecs  output  4  current right seconds digit, BCD 0-9, registered.
leftSecs  output  3  current left seconds digit, 0-5, registered.
sec_tick  output  1  one-cycle pulse, high in the cycle the digits advance.
min_carry  output  1  one-cycle pulse, high in the cycle the digits wrap 59->00.
load_err  output  1  one-cycle pulse, high in the cycle after a rejected load.

Behaviour:
- Reset (rst=1 at edge): prescaler=0, rightSecs=0, leftSecs=0, sec_tick=0, min_carry=0, load_err=0. rst overrides every other input.
- Priority below reset: clear > load > tick advance. A lower-priority event in the same cycle is discarded, not deferred.
- Prescaler:
  - When run=1, it counts 0..TICKS_PER_SEC-1 and then wraps to 0.
  - The cycle in which it is at TICKS_PER_SEC-1 with run=1 is the terminal cycle. At that edge the digits advance, and sec_tick is 1 for the following cycle (registered, aligned with the new digit values).
  - When run=0, the prescaler holds its value and no tick is produced. Resuming continues from the held count, so the partial second is not lost.
- Digit advance:
  - rightSecs<9: rightSecs+1.
  - rightSecs=9: rightSecs=0; leftSecs+1 if leftSecs<5.
  - right=9 and left=5: both become 0, and min_carry=1 in the same cycle as sec_tick.
- Width rules: rightSecs never exceeds 9 and leftSecs never exceeds 5, under all input sequences.
- clear (no rst): digits=00 and prescaler=0 at the next edge; sec_tick and min_carry stay 0 even if that cycle was terminal. The run level is unaffected.
- load, valid case (load_right<=9 and load_left<=5):
  - Digits take the preset values at the next edge and prescaler=0.
  - No tick or carry is produced for that cycle.
  - load_err=0.
- load, invalid case: digits and prescaler are unchanged and counting continues normally; load_err=1 for one cycle. If that cycle was terminal, the tick still occurs.
- Load and clear behave identically with run=0 or run=1.
- Pulses: sec_tick, min_carry and load_err are each high for exactly one cycle per event and never stretch.
- Latency: the outputs change one clk edge after the causing input or terminal count.
- Outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Reset and first second (TICKS_PER_SEC=4): rst for 2 cycles, then run=1 -> outputs 00 with pulses 0; first sec_tick on the 4th edge after rst deasserts; rightSecs=1; sec_tick then recurs every 4 cycles.
- Full-minute wrap: run for 60 ticks from 00 -> digits go 09->10 and 49->50 correctly, and 59->00 with sec_tick=1 and min_carry=1 in the same cycle; min_carry is never high at any other time.
- Pause/resume: drop run after 2 of 4 cycles, hold 10 cycles, reassert -> digits are frozen while run=0; the next tick comes 2 cycles after resume.
- Valid load: load with right=7, left=5 -> 57 on the next edge, prescaler restarts; after 3 ticks the digits are 00 with min_carry=1.
- Invalid load: load_right=10 at 23, and separately load_left=6 -> digits stay 23, load_err pulses once for each, counting continues.
- Collisions: clear and load together -> 00 with load ignored; clear in a terminal cycle -> 00 with no sec_tick; rst during load -> 00 with load_err=0.

Source files
------------

// File: rtl/seconds_counter_if.sv
// seconds_counter_if
//   Bundle of control inputs and time outputs for the seconds counter.
//   master : the controlling side (drives run/clear/load and presets,
//            observes the digits and pulses).
//   slave  : the seconds_counter itself.
//
//   Signals
//     run         level, 1 = time advances
//     clear       one-cycle strobe, zero digits and prescaler
//     load        one-cycle strobe, load load_right/load_left if valid
//     load_right  preset right digit (0-9 accepted)
//     load_left   preset left digit (0-5 accepted)
//     rightSecs   current right seconds digit (BCD 0-9)
//     leftSecs    current left seconds digit (0-5)
//     sec_tick    one-cycle pulse aligned with each digit advance
//     min_carry   one-cycle pulse aligned with the 59->00 advance
//     load_err    one-cycle pulse the cycle after a rejected load
//
//   Handshake semantics: there is no valid/ready pair. clear and load are
//   single-cycle strobes consumed at the next rising edge unconditionally
//   (the block is always ready); sec_tick, min_carry and load_err act as
//   single-cycle "valid" qualifiers for the digit values presented in the
//   same cycle.
interface seconds_counter_if;
  logic       run;
  logic       clear;
  logic       load;
  logic [3:0] load_right;
  logic [2:0] load_left;
  logic [3:0] rightSecs;
  logic [2:0] leftSecs;
  logic       sec_tick;
  logic       min_carry;
  logic       load_err;

  modport master (
    output run, clear, load, load_right, load_left,
    input  rightSecs, leftSecs, sec_tick, min_carry, load_err
  );

  modport slave (
    input  run, clear, load, load_right, load_left,
    output rightSecs, leftSecs, sec_tick, min_carry, load_err
  );
endinterface

// File: rtl/seconds_counter.sv
// seconds_counter
//   Divides clk down to a 1 Hz tick and keeps two seconds digits
//   (right 0-9, left 0-5) for the display controller. Produces a
//   one-cycle min_carry on 59->00 for the minutes stage. Supports
//   run/stop, clear and a validated preset load.
//
//   Ports
//     clk   system clock, rising edge
//     rst   synchronous reset, active-high, overrides everything
//     bus   seconds_counter_if.slave (controls in, digits/pulses out)
//
//   Parameters
//     TICKS_PER_SEC  clk cycles per second (>= 2)
//     PRESC_W        prescaler width, 2^PRESC_W >= TICKS_PER_SEC
//
//   Priority below reset: clear > valid load > tick advance. A lower
//   priority event in the same cycle is dropped, not deferred. A rejected
//   load is not an event for priority purposes: counting proceeds.
//   All outputs are registered.
module seconds_counter #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int PRESC_W       = 26
) (
  input logic              clk,
  input logic              rst,
  seconds_counter_if.slave bus
);

  localparam logic [PRESC_W-1:0] TERM_COUNT = PRESC_W'(TICKS_PER_SEC - 1);

  logic [PRESC_W-1:0] presc;
  logic               terminal;
  logic               load_ok;
  logic               at_59;

  // >= rather than == so an out-of-range prescaler can never get stuck.
  assign terminal = bus.run && (presc >= TERM_COUNT);
  assign load_ok  = (bus.load_right <= 4'd9) && (bus.load_left <= 3'd5);
  assign at_59    = (bus.rightSecs >= 4'd9) && (bus.leftSecs >= 3'd5);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc         <= '0;
      bus.rightSecs <= 4'd0;
      bus.leftSecs  <= 3'd0;
      bus.sec_tick  <= 1'b0;
      bus.min_carry <= 1'b0;
      bus.load_err  <= 1'b0;
    end else begin
      // Pulses default low so each event produces exactly one cycle.
      bus.sec_tick  <= 1'b0;
      bus.min_carry <= 1'b0;
      bus.load_err  <= 1'b0;

      if (bus.clear) begin
        presc         <= '0;
        bus.rightSecs <= 4'd0;
        bus.leftSecs  <= 3'd0;
      end else if (bus.load && load_ok) begin
        presc         <= '0;
        bus.rightSecs <= bus.load_right;
        bus.leftSecs  <= bus.load_left;
      end else begin
        if (bus.load) begin
          bus.load_err <= 1'b1;
        end
        if (terminal) begin
          presc        <= '0;
          bus.sec_tick <= 1'b1;
          // Saturating compares keep the digits in range whatever happens.
          if (bus.rightSecs >= 4'd9) begin
            bus.rightSecs <= 4'd0;
            if (bus.leftSecs >= 3'd5) begin
              bus.leftSecs <= 3'd0;
            end else begin
              bus.leftSecs <= bus.leftSecs + 3'd1;
            end
          end else begin
            bus.rightSecs <= bus.rightSecs + 4'd1;
          end
          bus.min_carry <= at_59;
        end else if (bus.run) begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seconds_counter.sv
// tb_seconds_counter
//   Directed bench for seconds_counter with TICKS_PER_SEC=4. Expected
//   pulse events are queued by the driver; a negedge monitor pops one
//   entry whenever sec_tick, min_carry or load_err is high. The driver
//   also checks the full output snapshot at chosen points.
//   Snapshot layout: {rightSecs[3:0], leftSecs[2:0], sec_tick, min_carry, load_err}
module tb_seconds_counter;

  localparam int TPS = 4;
  localparam int PW  = 3;

  logic clk;
  logic rst;
  seconds_counter_if bus();

  seconds_counter #(
    .TICKS_PER_SEC(TPS),
    .PRESC_W      (PW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [9:0] exp_q[$];
  int tests_run    = 0;
  int tests_failed = 0;

  function automatic logic [9:0] mk(int r, int l, bit t, bit c, bit e);
    logic [3:0] rr;
    logic [2:0] ll;
    rr = 4'(r);
    ll = 3'(l);
    return {rr, ll, t, c, e};
  endfunction

  function automatic logic [9:0] obs();
    return {bus.rightSecs, bus.leftSecs, bus.sec_tick, bus.min_carry, bus.load_err};
  endfunction

  task automatic cmp(input string name, input logic [9:0] act, input logic [9:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got r=%0d l=%0d tick=%b carry=%b err=%b, expected r=%0d l=%0d tick=%b carry=%b err=%b",
               name, act[9:6], act[5:3], act[2], act[1], act[0],
               exp[9:6], exp[5:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Monitor: every pulse the DUT presents must match the next queued event.
  always @(negedge clk) begin
    if (bus.sec_tick === 1'b1 || bus.min_carry === 1'b1 || bus.load_err === 1'b1) begin
      if (exp_q.size() == 0) begin
        cmp("unexpected_pulse", obs(), 10'd0);
      end else begin
        cmp("pulse_event", obs(), exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int r, input int l);
    bus.load_right = 4'(r);
    bus.load_left  = 3'(l);
    bus.load       = 1'b1;
    adv(1);
    bus.load       = 1'b0;
  endtask

  // Global time bound.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time bound, got no finish, expected finish");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst            = 1'b1;
    bus.run        = 1'b0;
    bus.clear      = 1'b0;
    bus.load       = 1'b0;
    bus.load_right = 4'd0;
    bus.load_left  = 3'd0;

    adv(2);
    cmp("reset_state", obs(), mk(0, 0, 0, 0, 0));

    // Full minute from 00: 60 ticks, carry only on the last.
    for (int i = 1; i <= 60; i++) begin
      exp_q.push_back(mk(i % 10, (i / 10) % 6, 1'b1, (i == 60), 1'b0));
    end
    rst     = 1'b0;
    bus.run = 1'b1;
    adv(3);
    cmp("pre_first_tick", obs(), mk(0, 0, 0, 0, 0));
    adv(1);
    cmp("first_tick", obs(), mk(1, 0, 1, 0, 0));
    adv(4);
    cmp("second_tick", obs(), mk(2, 0, 1, 0, 0));
    adv(32);
    cmp("tick_10", obs(), mk(0, 1, 1, 0, 0));
    adv(160);
    cmp("tick_50", obs(), mk(0, 5, 1, 0, 0));
    adv(40);
    cmp("wrap_59_00", obs(), mk(0, 0, 1, 1, 0));

    // Pause after 2 of 4 cycles, hold 10 cycles, resume.
    adv(2);
    bus.run = 1'b0;
    adv(10);
    cmp("paused_frozen", obs(), mk(0, 0, 0, 0, 0));
    exp_q.push_back(mk(1, 0, 1, 0, 0));
    bus.run = 1'b1;
    adv(1);
    cmp("resume_no_early_tick", obs(), mk(0, 0, 0, 0, 0));
    adv(1);
    cmp("resume_tick_after_2", obs(), mk(1, 0, 1, 0, 0));

    // Valid load 57, then three ticks to 00 with carry.
    do_load(7, 5);
    cmp("valid_load_57", obs(), mk(7, 5, 0, 0, 0));
    exp_q.push_back(mk(8, 5, 1, 0, 0));
    exp_q.push_back(mk(9, 5, 1, 0, 0));
    exp_q.push_back(mk(0, 0, 1, 1, 0));
    adv(3);
    cmp("load_restarts_prescaler", obs(), mk(7, 5, 0, 0, 0));
    adv(9);
    cmp("load_57_wrap", obs(), mk(0, 0, 1, 1, 0));

    // Invalid loads at 23: digits hold, load_err pulses, counting continues.
    do_load(3, 2);
    cmp("valid_load_23", obs(), mk(3, 2, 0, 0, 0));
    exp_q.push_back(mk(3, 2, 0, 0, 1));
    do_load(10, 2);
    cmp("bad_right_err", obs(), mk(3, 2, 0, 0, 1));
    exp_q.push_back(mk(3, 2, 0, 0, 1));
    do_load(3, 6);
    cmp("bad_left_err", obs(), mk(3, 2, 0, 0, 1));
    exp_q.push_back(mk(4, 2, 1, 0, 0));
    adv(1);
    cmp("err_one_cycle", obs(), mk(3, 2, 0, 0, 0));
    adv(1);
    cmp("count_continued", obs(), mk(4, 2, 1, 0, 0));

    // Invalid load in a terminal cycle: tick and error together.
    adv(3);
    exp_q.push_back(mk(5, 2, 1, 0, 1));
    do_load(15, 0);
    cmp("bad_load_terminal", obs(), mk(5, 2, 1, 0, 1));

    // Clear together with a valid load: clear wins.
    bus.clear = 1'b1;
    do_load(4, 4);
    bus.clear = 1'b0;
    cmp("clear_beats_load", obs(), mk(0, 0, 0, 0, 0));

    // Clear in a terminal cycle: no tick.
    adv(3);
    bus.clear = 1'b1;
    adv(1);
    bus.clear = 1'b0;
    cmp("clear_terminal_no_tick", obs(), mk(0, 0, 0, 0, 0));

    // Reset during loads (invalid then valid).
    do_load(3, 1);
    cmp("load_31", obs(), mk(3, 1, 0, 0, 0));
    rst = 1'b1;
    do_load(10, 6);
    rst = 1'b0;
    cmp("rst_beats_bad_load", obs(), mk(0, 0, 0, 0, 0));
    rst = 1'b1;
    do_load(9, 5);
    rst = 1'b0;
    cmp("rst_beats_good_load", obs(), mk(0, 0, 0, 0, 0));

    // Load and clear with run=0.
    bus.run = 1'b0;
    do_load(4, 3);
    cmp("load_while_stopped", obs(), mk(4, 3, 0, 0, 0));
    adv(6);
    cmp("stopped_hold", obs(), mk(4, 3, 0, 0, 0));
    bus.clear = 1'b1;
    adv(1);
    bus.clear = 1'b0;
    cmp("clear_while_stopped", obs(), mk(0, 0, 0, 0, 0));

    // Count again from a clean prescaler.
    exp_q.push_back(mk(1, 0, 1, 0, 0));
    bus.run = 1'b1;
    adv(4);
    cmp("restart_tick", obs(), mk(1, 0, 1, 0, 0));
    bus.run = 1'b0;
    adv(2);

    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL queue_drained: got %0d pending events, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
